// File: rtl/bf_pkg.sv
// Shared constants and helpers for the beamformer control generator.
package bf_pkg;

  localparam logic [1:0] LO_POS  = 2'b01;
  localparam logic [1:0] LO_NEG  = 2'b10;
  localparam logic [1:0] LO_ZERO = 2'b00;

  localparam logic [1:0] SEL_COS1 = 2'd0;
  localparam logic [1:0] SEL_SIN1 = 2'd1;
  localparam logic [1:0] SEL_COS2 = 2'd2;
  localparam logic [1:0] SEL_SIN2 = 2'd3;

  // The four weight words held for one channel, indexed by SEL_*.
  typedef logic [3:0][7:0] ch_words_max_t;

  // Quadrature LO phase p: I = +1,0,-1,0 and Q = 0,+1,0,-1.
  function automatic logic [1:0] lo_i_of(input logic [1:0] p);
    case (p)
      2'd0:    lo_i_of = LO_POS;
      2'd2:    lo_i_of = LO_NEG;
      default: lo_i_of = LO_ZERO;
    endcase
  endfunction

  function automatic logic [1:0] lo_q_of(input logic [1:0] p);
    case (p)
      2'd1:    lo_q_of = LO_POS;
      2'd3:    lo_q_of = LO_NEG;
      default: lo_q_of = LO_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/bf_prescaler.sv
// Prescale strobe generator: one-cycle PS_STB every max(PS_RATIO,2) cycles.
module bf_prescaler #(
  parameter int PS_W = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [PS_W-1:0] PS_RATIO,
  output logic            PS_STB
);

  logic [PS_W-1:0] cnt;
  logic [PS_W-1:0] r_q;
  logic [PS_W-1:0] r_in;
  logic            wrap;

  assign r_in = (PS_RATIO < PS_W'(2)) ? PS_W'(2) : PS_RATIO;
  assign wrap = (cnt == r_q - PS_W'(1));

  // The ratio is latched only at the wrap so a period is never cut short.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt    <= '0;
      r_q    <= r_in;
      PS_STB <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      r_q    <= r_in;
      PS_STB <= 1'b0;
    end else begin
      cnt    <= cnt + PS_W'(1);
      PS_STB <= (cnt + PS_W'(1) == r_q - PS_W'(1));
    end
  end

endmodule

// File: rtl/bf_ctrl_gen.sv
// Beamformer control generator: prescale strobe, quadrature LO and a
// double-buffered weight bank. Optional readback port: BF_WEIGHT_READBACK_EN.
module bf_ctrl_gen
  import bf_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int W_BITS = 5,
  parameter int PS_W   = 4,
  parameter int CH_W   = 3
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [PS_W-1:0]          PS_RATIO,
  input  logic                     WR_VALID,
  output logic                     WR_READY,
  input  logic [CH_W-1:0]          WR_CH,
  input  logic [1:0]               WR_SEL,
  input  logic [W_BITS-1:0]        WR_DATA,
  input  logic                     COMMIT_REQ,
  output logic                     COMMIT_ACK,
  output logic                     WR_ERR,
  output logic                     PS_STB,
  output logic [1:0]               LO_I,
  output logic [1:0]               LO_Q,
  output logic [NUM_CH*W_BITS-1:0] W_COS_1,
  output logic [NUM_CH*W_BITS-1:0] W_SIN_1,
  output logic [NUM_CH*W_BITS-1:0] W_COS_2,
  output logic [NUM_CH*W_BITS-1:0] W_SIN_2
`ifdef BF_WEIGHT_READBACK_EN
  ,
  input  logic [CH_W-1:0]          RD_CH,
  input  logic [1:0]               RD_SEL,
  output logic [W_BITS-1:0]        RD_DATA
`endif
);

  typedef logic [NUM_CH-1:0][3:0][W_BITS-1:0] bank_t;

  bank_t      shadow;
  bank_t      active;
  logic       pending;
  logic       wr_fire;
  logic       ch_ok;
  logic [1:0] lo_cnt;
  logic [1:0] lo_nxt;

  bf_prescaler #(.PS_W(PS_W)) u_prescaler (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .PS_RATIO (PS_RATIO),
    .PS_STB   (PS_STB)
  );

  // Handshake: a write transfers on any edge where WR_VALID && WR_READY;
  // WR_READY drops while a commit is pending so the shadow bank is frozen.
  assign WR_READY   = !pending;
  assign wr_fire    = WR_VALID && !pending;
  assign ch_ok      = int'(WR_CH) < NUM_CH;
  assign COMMIT_ACK = pending && PS_STB;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      WR_ERR  <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (ch_ok) shadow[WR_CH][WR_SEL] <= WR_DATA;
        else       WR_ERR                <= 1'b1;
      end
      // The ack edge takes priority, so a request held through it is dropped.
      if (COMMIT_ACK) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (COMMIT_REQ) begin
        pending <= 1'b1;
      end
    end
  end

  assign lo_nxt = lo_cnt + 2'd1;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      lo_cnt <= 2'd0;
      LO_I   <= lo_i_of(2'd0);
      LO_Q   <= lo_q_of(2'd0);
    end else begin
      lo_cnt <= lo_nxt;
      LO_I   <= lo_i_of(lo_nxt);
      LO_Q   <= lo_q_of(lo_nxt);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign W_COS_1[k*W_BITS +: W_BITS] = active[k][SEL_COS1];
    assign W_SIN_1[k*W_BITS +: W_BITS] = active[k][SEL_SIN1];
    assign W_COS_2[k*W_BITS +: W_BITS] = active[k][SEL_COS2];
    assign W_SIN_2[k*W_BITS +: W_BITS] = active[k][SEL_SIN2];
  end

`ifdef BF_WEIGHT_READBACK_EN
  always_ff @(posedge CLOCK) begin
    if (RESET)                     RD_DATA <= '0;
    else if (int'(RD_CH) < NUM_CH) RD_DATA <= active[RD_CH][RD_SEL];
    else                           RD_DATA <= '0;
  end
`endif

endmodule

// File: tb/tb_bf_ctrl_gen.sv
// Directed bench for bf_ctrl_gen (six channels so WR_CH=7 is out of range).
module tb_bf_ctrl_gen;

  localparam int NUM_CH = 6;
  localparam int W_BITS = 5;
  localparam int PS_W   = 4;
  localparam int CH_W   = 3;
  localparam int BW     = NUM_CH * W_BITS;

  logic              CLOCK;
  logic              RESET;
  logic [PS_W-1:0]   PS_RATIO;
  logic              WR_VALID;
  logic              WR_READY;
  logic [CH_W-1:0]   WR_CH;
  logic [1:0]        WR_SEL;
  logic [W_BITS-1:0] WR_DATA;
  logic              COMMIT_REQ;
  logic              COMMIT_ACK;
  logic              WR_ERR;
  logic              PS_STB;
  logic [1:0]        LO_I;
  logic [1:0]        LO_Q;
  logic [BW-1:0]     W_COS_1;
  logic [BW-1:0]     W_SIN_1;
  logic [BW-1:0]     W_COS_2;
  logic [BW-1:0]     W_SIN_2;
`ifdef BF_WEIGHT_READBACK_EN
  logic [CH_W-1:0]   RD_CH;
  logic [1:0]        RD_SEL;
  logic [W_BITS-1:0] RD_DATA;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bf_ctrl_gen #(
    .NUM_CH(NUM_CH), .W_BITS(W_BITS), .PS_W(PS_W), .CH_W(CH_W)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .PS_RATIO   (PS_RATIO),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_CH      (WR_CH),
    .WR_SEL     (WR_SEL),
    .WR_DATA    (WR_DATA),
    .COMMIT_REQ (COMMIT_REQ),
    .COMMIT_ACK (COMMIT_ACK),
    .WR_ERR     (WR_ERR),
    .PS_STB     (PS_STB),
    .LO_I       (LO_I),
    .LO_Q       (LO_Q),
    .W_COS_1    (W_COS_1),
    .W_SIN_1    (W_SIN_1),
    .W_COS_2    (W_COS_2),
    .W_SIN_2    (W_SIN_2)
`ifdef BF_WEIGHT_READBACK_EN
    ,
    .RD_CH      (RD_CH),
    .RD_SEL     (RD_SEL),
    .RD_DATA    (RD_DATA)
`endif
  );

  // Clock and watchdog
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers: inputs change 1 time unit after the edge, outputs sampled there.
  task automatic tick();
    @(posedge CLOCK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max, output logic got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (COMMIT_ACK) got = 1'b1;
    end
  endtask

  function automatic logic [1:0] exp_lo_i(input int p);
    case (p % 4)
      0:       exp_lo_i = 2'b01;
      2:       exp_lo_i = 2'b10;
      default: exp_lo_i = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_lo_q(input int p);
    case (p % 4)
      1:       exp_lo_q = 2'b01;
      3:       exp_lo_q = 2'b10;
      default: exp_lo_q = 2'b00;
    endcase
  endfunction

  logic [BW-1:0] exp_cos1;
  logic [BW-1:0] exp_sin2;
  logic          got;
  int            n_ack;

  initial begin
    RESET = 1'b1; PS_RATIO = 4'd8;
    WR_VALID = 1'b0; WR_CH = '0; WR_SEL = '0; WR_DATA = '0; COMMIT_REQ = 1'b0;
`ifdef BF_WEIGHT_READBACK_EN
    RD_CH = '0; RD_SEL = '0;
`endif
    tick(); tick();
    RESET = 1'b0;
    cyc = 1;  // first cycle after the last reset edge

    check("rst_ps_stb", PS_STB, 1'b0);
    check("rst_wr_ready", WR_READY, 1'b1);
    check("rst_ack", COMMIT_ACK, 1'b0);
    check("rst_wr_err", WR_ERR, 1'b0);
    check("rst_cos1", W_COS_1, '0);
    check("rst_sin2", W_SIN_2, '0);

    // Ratio 8: strobe first at cycle 8; LO phase starts at cycle 1.
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      check("ps_stb_r8", PS_STB, (k == 8));
      check("lo_i", LO_I, exp_lo_i(k - 1));
      check("lo_q", LO_Q, exp_lo_q(k - 1));
    end

    // Ratio 8 -> 3 mid-period, then 3 -> 0 (period 2), then 4 for commit tests.
    for (int k = 9; k <= 26; k++) begin
      tick();
      if (cyc == 10) PS_RATIO = 4'd3;
      if (cyc == 20) PS_RATIO = 4'd0;
      if (cyc == 26) PS_RATIO = 4'd4;
      check("ps_stb_seq", PS_STB, (cyc inside {16, 19, 22, 24, 26}));
      check("lo_i_run", LO_I, exp_lo_i(cyc - 1));
    end

    // Write ch5 cos1 without commit: active bank must not move.
    tick();  // cycle 27
    WR_VALID = 1'b1; WR_CH = 3'd5; WR_SEL = 2'd0; WR_DATA = 5'h13;
    tick();  // cycle 28
    WR_VALID = 1'b0;
    check("no_commit_cos1", W_COS_1, '0);
    check("ready_idle", WR_READY, 1'b1);
    tick();  // cycle 29
    check("no_commit_cos1_b", W_COS_1, '0);
    COMMIT_REQ = 1'b1;
    tick();  // cycle 30: strobe cycle, pending set at previous edge
    COMMIT_REQ = 1'b0;
    check("ack_first", COMMIT_ACK, 1'b1);
    check("ack_on_stb", PS_STB, 1'b1);
    check("ready_pending", WR_READY, 1'b0);
    check("cos1_before_load", W_COS_1, '0);
    tick();  // cycle 31
    exp_cos1 = '0;
    exp_cos1[25 +: 5] = 5'h13;
    check("cos1_committed", W_COS_1, exp_cos1);
    check("sin1_untouched", W_SIN_1, '0);
    check("ack_one_cycle", COMMIT_ACK, 1'b0);
    check("ready_after_ack", WR_READY, 1'b1);

    // Write in the same cycle as the request; hold request; blocked write.
    COMMIT_REQ = 1'b1;
    WR_VALID = 1'b1; WR_CH = 3'd2; WR_SEL = 2'd3; WR_DATA = 5'h0A;
    tick();  // cycle 32
    check("ready_low_32", WR_READY, 1'b0);
    check("ack_low_32", COMMIT_ACK, 1'b0);
    WR_CH = 3'd0; WR_SEL = 2'd0; WR_DATA = 5'h1F;
    tick();  // cycle 33
    check("ready_low_33", WR_READY, 1'b0);
    check("ack_low_33", COMMIT_ACK, 1'b0);
    tick();  // cycle 34
    check("ack_second", COMMIT_ACK, 1'b1);
    check("ack_second_stb", PS_STB, 1'b1);
    COMMIT_REQ = 1'b0;
    WR_VALID = 1'b0;
    tick();  // cycle 35
    exp_sin2 = '0;
    exp_sin2[10 +: 5] = 5'h0A;
    check("same_cycle_write", W_SIN_2, exp_sin2);
    check("blocked_write", W_COS_1, exp_cos1);
    n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      if (COMMIT_ACK) n_ack++;
      tick();
    end
    check("no_extra_ack", n_ack, 0);

`ifdef BF_WEIGHT_READBACK_EN
    RD_CH = 3'd5; RD_SEL = 2'd0;
    tick();
    check("rd_ch5_cos1", RD_DATA, 5'h13);
    RD_CH = 3'd2; RD_SEL = 2'd3;
    tick();
    check("rd_ch2_sin2", RD_DATA, 5'h0A);
    RD_CH = 3'd7; RD_SEL = 2'd0;
    tick();
    check("rd_out_of_range", RD_DATA, '0);
`endif

    // Out-of-range channel: flagged, dropped, sticky.
    WR_VALID = 1'b1; WR_CH = 3'd7; WR_SEL = 2'd0; WR_DATA = 5'h1F;
    tick();
    WR_VALID = 1'b0;
    check("wr_err_set", WR_ERR, 1'b1);
    check("wr_err_ready", WR_READY, 1'b1);
    COMMIT_REQ = 1'b1;
    tick();
    COMMIT_REQ = 1'b0;
    wait_ack(8, got);
    check("ack_seen_err", got, 1'b1);
    tick();
    check("err_bank_cos1", W_COS_1, exp_cos1);
    check("err_bank_sin1", W_SIN_1, '0);
    check("wr_err_sticky", WR_ERR, 1'b1);

    // Reset while a commit is pending.
    WR_VALID = 1'b1; WR_CH = 3'd1; WR_SEL = 2'd2; WR_DATA = 5'h07;
    COMMIT_REQ = 1'b1;
    tick();
    WR_VALID = 1'b0; COMMIT_REQ = 1'b0;
    check("pending_pre_reset", WR_READY, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mid_rst_ack", COMMIT_ACK, 1'b0);
    check("mid_rst_err", WR_ERR, 1'b0);
    check("mid_rst_ready", WR_READY, 1'b1);
    check("mid_rst_cos1", W_COS_1, '0);
    check("mid_rst_sin2", W_SIN_2, '0);
    check("mid_rst_lo_i", LO_I, 2'b01);
    n_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      if (COMMIT_ACK) n_ack++;
      check("post_rst_stb", PS_STB, (k == 4));
    end
    check("post_rst_no_ack", n_ack, 0);
    check("post_rst_cos2", W_COS_2, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf_ctrl_gen.md
Name: bf_ctrl_gen

Overview:
Parametrised control and timing generator for the beamformer datapath. It produces a single-cycle prescale strobe on CLOCK with a programmable ratio, in place of a derived clock. It also produces the quadrature LO sequence and holds a double-buffered per-channel weight bank. Weights are staged through a valid/ready write port and committed atomically to all channels on a prescale strobe, so phase-shift stages never see a half-updated weight set.

Parameters:
NUM_CH, 8, number of beamformer channels
W_BITS, 5, width of each weight word
PS_W, 4, width of the prescale ratio input
CH_W, 3, width of the channel index (must satisfy 2**CH_W >= NUM_CH)

Ports:
CLOCK  input  1  system clock
RESET  input  1  synchronous, active-high reset
PS_RATIO  input  PS_W  prescale divide ratio; values 0 and 1 are treated as 2
WR_VALID  input  1  weight write request
WR_READY  output  1  write accepted when high with WR_VALID
WR_CH  input  CH_W  target channel
WR_SEL  input  2  weight select: 0=cos1, 1=sin1, 2=cos2, 3=sin2
WR_DATA  input  W_BITS  weight value
COMMIT_REQ  input  1  request to copy the shadow bank to the active bank
COMMIT_ACK  output  1  one-cycle pulse when the active bank updates
WR_ERR  output  1  sticky flag: a write targeted WR_CH >= NUM_CH
PS_STB  output  1  prescale strobe, one CLOCK cycle wide
LO_I  output  2  LO in-phase: 01=+1, 10=-1, 00=0
LO_Q  output  2  LO quadrature, same encoding as LO_I
W_COS_1  output  NUM_CH*W_BITS  active cos1 weights, channel k at bits [k*W_BITS +: W_BITS]
W_SIN_1  output  NUM_CH*W_BITS  active sin1 weights, same packing
W_COS_2  output  NUM_CH*W_BITS  active cos2 weights, same packing
W_SIN_2  output  NUM_CH*W_BITS  active sin2 weights, same packing

Behaviour:
Reset values:
- Prescale counter 0; PS_STB 0.
- LO counter 0, so LO_I=01 and LO_Q=00 on the first cycle after reset.
- Shadow and active banks all 0.
- pending 0, COMMIT_ACK 0, WR_ERR 0; WR_READY 1.
- Reset mid-commit discards the pending commit and clears both banks.

Prescaler:
- R = max(PS_RATIO, 2).
- The counter counts 0..R-1; PS_STB is registered high in the cycle the counter equals R-1, then the counter wraps to 0.
- PS_RATIO is sampled only at the wrap. A change mid-period takes effect for the next period and never produces a short or missed strobe.

LO generator:
- 2-bit free-running counter.
- LO_I sequence: +1, 0, -1, 0.
- LO_Q sequence: 0, +1, 0, -1.
- Both outputs are registered.

Write port:
- WR_READY = !pending.
- An accepted write (WR_VALID && WR_READY) updates shadow[WR_CH][WR_SEL] at that edge.
- If WR_CH >= NUM_CH, the write is accepted but dropped and WR_ERR is set. WR_ERR clears only on RESET.
- Active outputs are unaffected by writes until a commit.

Commit:
- COMMIT_REQ while pending==0 sets pending at that edge. COMMIT_REQ while pending==1 is ignored.
- A write accepted in the same cycle as COMMIT_REQ is included in the commit.
- At the first edge where pending==1 and PS_STB==1, all four active banks load from the shadow bank in that one edge. COMMIT_ACK is high for that cycle only and pending clears.
- The earliest ACK is the cycle after the request's edge. A PS_STB coincident with COMMIT_REQ does not commit.
- Worst-case latency from request to ACK is R cycles.

Optional Feature:
BF_WEIGHT_READBACK_EN
- With the macro defined, the block adds inputs RD_CH (CH_W) and RD_SEL (2), and output RD_DATA (W_BITS).
- RD_DATA is registered: it returns the active-bank word one cycle after the address.
- An out-of-range RD_CH returns 0.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Package bf_pkg holds:
  - LO encoding constants LO_POS=2'b01, LO_NEG=2'b10, LO_ZERO=2'b00.
  - Weight-select constants SEL_COS1..SEL_SIN2.
  - A packed weight-bank typedef.
- One sub-module, bf_prescaler: ratio clamp, counter and PS_STB generation.
- Weight bank, commit logic and LO generator stay in bf_ctrl_gen.

Test Plan:
- PS_RATIO=8 after reset -> PS_STB high every 8th cycle, first at cycle 8. Change to 3 mid-period -> current period completes at 8, then period 3. PS_RATIO=0 -> period 2.
- Free-running LO check -> LO_I cycles 01,00,10,00 and LO_Q cycles 00,01,00,10, starting the first cycle after reset.
- Write ch5 cos1=5'h13 with no commit -> W_COS_1[25+:5] stays 0. Assert COMMIT_REQ -> ACK coincides with next PS_STB; field reads 5'h13 and all other channels are unchanged.
- COMMIT_REQ held pending -> WR_READY=0 until ACK. A second COMMIT_REQ while pending produces no extra ACK. A write in the same cycle as COMMIT_REQ appears in the committed bank.
- Write to WR_CH=7 with NUM_CH=6 -> WR_ERR=1 and the bank is unchanged. RESET mid-pending -> no ACK, banks 0, WR_ERR 0.
- With BF_WEIGHT_READBACK_EN: RD_CH=5, RD_SEL=0 after the commit above -> RD_DATA=5'h13 one cycle later. RD_CH=7 -> RD_DATA=0.
